uart_tx_frame: RTL and testbench
================================

# uart_tx_frame

Parametrised UART transmitter: the next generation of the logic analyser's fixed 8N1 `uart_tx`. It adds configurable data width, parity and stop-bit count, plus an optional transmit FIFO so the capture-upload path can stream samples without gaps between frames. It sits between the sample/upload controller and the board's UART TX pin.

## Interface
- `CLK_FREQ`, 50_000_000: clock frequency in Hz.
- `BAUD_RATE`, 115200: line rate in bit/s; `BAUD_DIV = CLK_FREQ / BAUD_RATE` (integer truncation, must be ≥ 2).
- `DATA_BITS`, 8: payload bits per frame, legal range 5–9.
- `PARITY`, 0: parity mode; 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.
- `FIFO_DEPTH`, 16: FIFO entries, a power of 2 ≥ 2. Used only when `UART_TX_FIFO_EN` is defined.
- `clk` in 1: system clock. One clock only.
- `rst_n` in 1: reset, asynchronous, active-low.
- `tx_data` in DATA_BITS: payload word, transmitted LSB first.
- `tx_valid` in 1: the word on `tx_data` is valid.
- `tx_ready` out 1: the block accepts a word on this edge if `tx_valid` is high.
- `uart_tx` out 1: serial line, idle high.
- `tx_busy` out 1: a frame is on the line, or (with FIFO) words are still queued.

## Operation
- Handshake: a transfer occurs on a rising edge where `tx_valid && tx_ready`. `tx_data` is sampled on that edge only.
- FSM states and transitions:
  - IDLE → START on a transfer (no FIFO) or when the FIFO is non-empty (FIFO).
  - START → DATA.
  - DATA → PARITY if `PARITY != 0`, otherwise DATA → STOP.
  - PARITY → STOP.
  - STOP → IDLE, or STOP → START (FIFO only, see below).
- Every state lasts exactly `BAUD_DIV` clocks, timed by a baud counter that reloads on each state or bit change.
- DATA emits `DATA_BITS` bits, counted by a bit index. STOP lasts `STOP_BITS × BAUD_DIV` clocks.
- Line levels: start bit 0, stop bit(s) 1.
- Parity bit: even mode = XOR of payload; odd mode = inverted XOR. It is computed from the latched word.
- Frame length is `(1 + DATA_BITS + (PARITY!=0) + STOP_BITS) × BAUD_DIV` clocks.
- The payload is latched into a shift register when the frame starts. Changes on `tx_data` mid-frame have no effect.

## Timing
- Reset values: `uart_tx`=1, `tx_ready`=1, `tx_busy`=0, FSM=IDLE, FIFO empty, all counters 0.
- Reset asserted mid-frame: `uart_tx` goes high immediately (asynchronous) and the frame is abandoned. After release, the block is in IDLE.
- Without FIFO:
  - `tx_ready` = (state == IDLE).
  - `uart_tx` falls 1 clock after the accepting edge.
  - Back-to-back frames have at least 1 idle-high clock between the last stop bit and the next start bit.
- With FIFO:
  - `tx_ready` = !full.
  - A push into an empty FIFO reaches the line 2 clocks after the accepting edge (pop edge, then start bit).
  - On the last clock of STOP with the FIFO non-empty, the next word is popped and START follows with zero gap.
  - A simultaneous push and pop is legal at any occupancy, including full. `tx_ready` reflects full from the previous edge.
  - Pushes while full are impossible by handshake. `tx_valid` with `tx_ready` low is ignored.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. full/empty are derived from the MSB comparison.
- `tx_busy` = (state != IDLE) || !empty, registered.

## Configuration
- `UART_TX_FIFO_EN` defined:
  - A `FIFO_DEPTH` × `DATA_BITS` FIFO is instantiated in front of the serializer.
  - Timing follows the FIFO rules above.
- `UART_TX_FIFO_EN` undefined:
  - No storage beyond the shift register.
  - `tx_ready` is high only in IDLE.
  - `FIFO_DEPTH` is ignored.

## Structure
- The shared package `uart_pkg` holds:
  - the FSM state encoding (`ST_IDLE`, `ST_START`, `ST_DATA`, `ST_PARITY`, `ST_STOP`);
  - the parity-mode constants (`PAR_NONE`=0, `PAR_ODD`=1, `PAR_EVEN`=2);
  - a `baud_div` constant function.
- Sub-module `uart_tx_fifo`: synchronous FIFO with push/pop/full/empty. It is instantiated only under `UART_TX_FIFO_EN`.

## Test plan
All scenarios use 50 MHz and 115200 baud, so `BAUD_DIV`=434.
- 8N1, no FIFO, send 0xA5:
  - line bits 0,1,0,1,0,0,1,0,1,1, each 434 clocks;
  - frame is 4340 clocks;
  - `tx_ready` low for the whole frame.
- 8O1, send 0x00 → parity bit 1. 8E1, send 0xFF → parity bit 0. Frame is 4774 clocks.
- 7E2, send 0x5A (7-bit payload 0x5A) → 0,0,1,0,1,1,0,1, then parity 0, then two stop bits (868 clocks high).
- FIFO on, depth 4, push 0xA5, 0x5A, 0x00, 0xFF, 0x11 back-to-back:
  - first word popped immediately, so 4 words fit and `tx_ready` stays high through the 5th push;
  - a 6th push stalls until the first frame completes;
  - frames on the line have zero idle gap;
  - the receive monitor decodes the words in order.
- Assert `rst_n` low mid-data of 0xA5 → `uart_tx`=1 the same instant. After release, a new 0x3C transmits cleanly.
- Without FIFO, hold `tx_valid` high continuously with 0x55 → the gap between frames is ≥ 1 clock, and each frame decodes as 0x55.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encoding, parity-mode constants and baud divider helper
// for the UART transmit path.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Clocks per bit; integer truncation, callers keep the result >= 2.
  function automatic int baud_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous first-word-fall-through FIFO; pointers carry one extra
// wrap bit so full/empty come straight from a pointer compare.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter (5-9 data bits, none/odd/even parity, 1-2 stops).
// Define UART_TX_FIFO_EN to put a FIFO_DEPTH-entry transmit FIFO in front of the serializer.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 uart_tx,
  output logic                 tx_busy
);

  localparam int             BAUD_DIV  = baud_div(CLK_FREQ, BAUD_RATE);
  localparam int             CW        = $clog2(BAUD_DIV);
  localparam logic [CW-1:0]  BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [3:0]     DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic           PAR_EN    = (PARITY != PAR_NONE);
  localparam logic           PAR_INV   = (PARITY == PAR_ODD);

  logic [2:0]           state;
  logic [CW-1:0]        baud_cnt;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit;
  logic                 line_level;
  logic                 bit_end;
  logic                 stop_done;
  logic                 start_frame;
  logic                 word_avail;
  logic [DATA_BITS-1:0] frame_word;
  logic                 fifo_empty;

`ifdef UART_TX_FIFO_EN
  localparam logic CHAIN = 1'b1;
  logic fifo_full;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_valid && tx_ready),
    .wdata (tx_data),
    .pop   (start_frame),
    .rdata (frame_word),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign tx_ready   = !fifo_full;
  assign word_avail = !fifo_empty;
`else
  localparam logic CHAIN = 1'b0;

  assign tx_ready   = (state == ST_IDLE);
  assign word_avail = tx_valid;
  assign frame_word = tx_data;
  assign fifo_empty = 1'b1;
`endif

  assign bit_end   = (baud_cnt == BAUD_LAST);
  assign stop_done = (state == ST_STOP) && bit_end && (bit_idx == STOP_LAST);
  // With the FIFO, the last stop clock hands straight over to the next start bit.
  assign start_frame = word_avail && ((state == ST_IDLE) || (CHAIN && stop_done));

  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
    line_level = 1'b1;
    case (state)
      ST_START:  line_level = 1'b0;
      ST_DATA:   line_level = shift[0];
      ST_PARITY: line_level = par_bit;
      default:   line_level = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
      uart_tx  <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      uart_tx <= line_level;
      tx_busy <= (state != ST_IDLE) || !fifo_empty;
      if (start_frame) begin
        state    <= ST_START;
        baud_cnt <= '0;
        bit_idx  <= '0;
        shift    <= frame_word;
        par_bit  <= (^frame_word) ^ PAR_INV;
      end else if (state != ST_IDLE) begin
        if (!bit_end) begin
          baud_cnt <= baud_cnt + CW'(1);
        end else begin
          baud_cnt <= '0;
          case (state)
            ST_START: state <= ST_DATA;
            ST_DATA: begin
              if (bit_idx == DATA_LAST) begin
                bit_idx <= '0;
                state   <= PAR_EN ? ST_PARITY : ST_STOP;
              end else begin
                bit_idx <= bit_idx + 4'd1;
                shift   <= shift >> 1;
              end
            end
            ST_PARITY: state <= ST_STOP;
            ST_STOP: begin
              if (bit_idx == STOP_LAST) begin
                bit_idx <= '0;
                state   <= ST_IDLE;
              end else begin
                bit_idx <= bit_idx + 4'd1;
              end
            end
            default: state <= ST_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: four transmitters (8N1, 8O1, 8E1, 7E2) driven with directed and random words;
// a per-line monitor decodes frames against a positional bit model and a queue of expected words.
module tb_uart_tx_frame;

  localparam int BD          = 434;
  localparam int SEND_LIMIT  = 20000;
  localparam int IDLE_LIMIT  = 40000;
`ifdef UART_TX_FIFO_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef logic [8:0] word_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rst_mid_n;
  word_t      data  [4];
  logic       valid [4];
  wire  [3:0] line;
  wire  [3:0] ready;
  wire  [3:0] busy;
  wire  [3:0] rst_dut;

  word_t exp_q [4][$];
  int    gap_log [$];
  int    frames_exp  [4] = '{default: 0};
  int    frames_done [4] = '{default: 0};
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;

  assign rst_dut = {rst_n, rst_n, rst_n, rst_n & rst_mid_n};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_frame #(.CLK_FREQ(50_000_000), .BAUD_RATE(115200), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_dut[0]), .tx_data(data[0][7:0]), .tx_valid(valid[0]),
    .tx_ready(ready[0]), .uart_tx(line[0]), .tx_busy(busy[0]));

  uart_tx_frame #(.CLK_FREQ(50_000_000), .BAUD_RATE(115200), .DATA_BITS(8), .PARITY(1),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_dut[1]), .tx_data(data[1][7:0]), .tx_valid(valid[1]),
    .tx_ready(ready[1]), .uart_tx(line[1]), .tx_busy(busy[1]));

  uart_tx_frame #(.CLK_FREQ(50_000_000), .BAUD_RATE(115200), .DATA_BITS(8), .PARITY(2),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) dut_c (
    .clk(clk), .rst_n(rst_dut[2]), .tx_data(data[2][7:0]), .tx_valid(valid[2]),
    .tx_ready(ready[2]), .uart_tx(line[2]), .tx_busy(busy[2]));

  uart_tx_frame #(.CLK_FREQ(50_000_000), .BAUD_RATE(115200), .DATA_BITS(7), .PARITY(2),
                  .STOP_BITS(2), .FIFO_DEPTH(4)) dut_d (
    .clk(clk), .rst_n(rst_dut[3]), .tx_data(data[3][6:0]), .tx_valid(valid[3]),
    .tx_ready(ready[3]), .uart_tx(line[3]), .tx_busy(busy[3]));

  // Frame format of each instance, straight from its parameters.
  function automatic int dbits(input int id);
    return (id == 3) ? 7 : 8;
  endfunction

  function automatic int pmode(input int id);
    case (id)
      1:       return 1;
      2, 3:    return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int sbits(input int id);
    return (id == 3) ? 2 : 1;
  endfunction

  function automatic int nbits(input int id);
    return 1 + dbits(id) + ((pmode(id) != 0) ? 1 : 0) + sbits(id);
  endfunction

  function automatic word_t mask(input int id);
    return word_t'((1 << dbits(id)) - 1);
  endfunction

  // Level of bit position k of the frame carrying word w.
  function automatic logic frame_bit(input int id, input word_t w, input int k);
    if (k == 0) return 1'b0;
    if (k <= dbits(id)) return w[k-1];
    if (pmode(id) != 0 && k == dbits(id) + 1) return (pmode(id) == 1) ? ~(^w) : (^w);
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic monitor(input int id);
    int    gap;
    int    bad;
    int    nb;
    bit    aborted;
    word_t w;
    word_t got;
    gap = 0;
    nb  = nbits(id);
    forever begin
      @(negedge clk);
      if (!rst_dut[id]) begin
        gap = 0;
        continue;
      end
      if (line[id] === 1'b1) begin
        gap++;
        continue;
      end
      check($sformatf("dut%0d_frame_expected", id), exp_q[id].size() > 0, 1);
      if (exp_q[id].size() == 0) begin
        repeat (nb * BD - 1) @(negedge clk);
        gap = 0;
        continue;
      end
      w       = exp_q[id].pop_front();
      bad     = 0;
      got     = '0;
      aborted = 1'b0;
      for (int j = 0; j < nb * BD; j++) begin
        if (j > 0) @(negedge clk);
        if (!rst_dut[id]) begin
          aborted = 1'b1;
          break;
        end
        if (line[id] !== frame_bit(id, w, j / BD)) bad++;
        if (j / BD >= 1 && j / BD <= dbits(id) && j % BD == BD / 2) got[j/BD-1] = line[id];
      end
      if (aborted) begin
        gap = 0;
        continue;
      end
      check($sformatf("dut%0d_frame_bits_wrong", id), bad, 0);
      check($sformatf("dut%0d_decoded_word", id), got, w);
`ifndef UART_TX_FIFO_EN
      check($sformatf("dut%0d_idle_gap_ge1", id), gap >= 1, 1);
`endif
      if (id == 0) gap_log.push_back(gap);
      frames_done[id]++;
      gap = 0;
    end
  endtask

  initial monitor(0);
  initial monitor(1);
  initial monitor(2);
  initial monitor(3);

  // Offers w until accepted; the expected word is queued on the accepting edge.
  task automatic send(input int id, input word_t w, input bit hold, output int waited,
                      output int acc_cyc);
    word_t m;
    m      = w & mask(id);
    waited = 0;
    @(negedge clk);
    data[id]  = m;
    valid[id] = 1'b1;
    while (!ready[id] && waited < SEND_LIMIT) begin
      @(negedge clk);
      waited++;
    end
    check($sformatf("dut%0d_send_accepted", id), waited < SEND_LIMIT, 1);
    acc_cyc = cyc;
    if (waited < SEND_LIMIT) begin
      @(posedge clk);
      exp_q[id].push_back(m);
      frames_exp[id]++;
      #1;
    end
    if (!hold || waited >= SEND_LIMIT) begin
      valid[id] = 1'b0;
      data[id]  = word_t'($urandom) & mask(id);
    end
  endtask

  task automatic wait_idle(input int id);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q[id].size() != 0 || busy[id] !== 1'b0) && n < IDLE_LIMIT);
    check($sformatf("dut%0d_returns_idle", id), n < IDLE_LIMIT, 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic run_side(input int id, input word_t first);
    int wt;
    int c;
    send(id, first, 1'b0, wt, c);
    for (int k = 0; k < 3; k++) send(id, word_t'($urandom), 1'b0, wt, c);
    wait_idle(id);
  endtask

  task automatic run_main;
    int    wt;
    int    c;
    int    c1;
    int    low_cnt;
    word_t burst [5];
    burst   = '{9'hA5, 9'h5A, 9'h00, 9'hFF, 9'h11};
    low_cnt = 0;
    c1      = 0;

    send(0, 9'hA5, 1'b0, wt, c);
    for (int i = 0; i <= 4345; i++) begin
      @(negedge clk);
      if (i == LAT - 1) check("a5_line_high_before_start", line[0], 1);
      if (i == LAT)     check("a5_start_bit_latency", line[0], 0);
      if (i == 2000)    check("a5_busy_mid_frame", busy[0], 1);
`ifndef UART_TX_FIFO_EN
      if (!ready[0]) low_cnt++;
      if (i == 4340) check("a5_ready_back_after_frame", ready[0], 1);
`endif
    end
`ifndef UART_TX_FIFO_EN
    check("a5_ready_low_clocks", low_cnt, 4340);
`endif
    wait_idle(0);

    send(0, 9'hA5, 1'b0, wt, c);
    repeat (LAT + 868 + 200) @(negedge clk);
    check("rst_line_low_before", line[0], 0);
    #2;
    rst_mid_n = 1'b0;
    #1;
    check("rst_line_high_async", line[0], 1);
    check("rst_ready_high", ready[0], 1);
    check("rst_busy_low", busy[0], 0);
    frames_exp[0]--;
    repeat (3) @(negedge clk);
    rst_mid_n = 1'b1;

    send(0, 9'h3C, 1'b0, wt, c);
    for (int k = 0; k < 3; k++) send(0, word_t'($urandom), 1'b0, wt, c);
    wait_idle(0);

`ifndef UART_TX_FIFO_EN
    for (int k = 0; k < 3; k++) send(0, 9'h55, 1'b1, wt, c);
    @(negedge clk);
    valid[0] = 1'b0;
    wait_idle(0);
`else
    gap_log.delete();
    for (int k = 0; k < 5; k++) begin
      send(0, burst[k], 1'b0, wt, c);
      if (k == 0) c1 = c;
      check($sformatf("burst_push%0d_no_stall", k), wt, 0);
    end
    send(0, word_t'($urandom), 1'b0, wt, c);
    check("burst_push6_stalls_one_frame", (c - c1) >= 4300 && (c - c1) <= 4345, 1);
    wait_idle(0);
    check("burst_frame_count", gap_log.size(), 6);
    for (int k = 1; k < 6; k++)
      if (k < gap_log.size()) check($sformatf("burst_gap%0d_zero", k), gap_log[k], 0);
`endif
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    rst_mid_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      valid[i] = 1'b0;
      data[i]  = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("dut%0d_reset_line", i), line[i], 1);
      check($sformatf("dut%0d_reset_ready", i), ready[i], 1);
      check($sformatf("dut%0d_reset_busy", i), busy[i], 0);
    end
    rst_n = 1'b1;

    fork
      run_main();
      run_side(1, 9'h00);
      run_side(2, 9'hFF);
      run_side(3, 9'h5A);
    join

    repeat (10) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("dut%0d_queue_drained", i), exp_q[i].size(), 0);
      check($sformatf("dut%0d_frames_seen", i), frames_done[i], frames_exp[i]);
      check($sformatf("dut%0d_final_busy", i), busy[i], 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
